// File: rtl/led_ctrl.sv
// Memory-mapped LED bank controller: per-channel static/blink, shared blink divider,
// global PWM dimming and selectable pin polarity, with a registered pin stage.
module led_ctrl #(
    parameter int               N_LED      = 8,
    parameter int               DIV_W      = 24,
    parameter int               PWM_W      = 4,
    parameter logic [DIV_W-1:0] DIV_RST    = '0,
    parameter bit               ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WE,
    input  logic [1:0]       Addr,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    output logic [N_LED-1:0] led
);

    // Bus protocol: WE is a single-cycle write strobe with no backpressure; every
    // cycle with WE=1 at a rising edge commits Din to the register selected by Addr.

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_MODE = 2'd1;
    localparam logic [1:0] A_DIV  = 2'd2;
    localparam logic [1:0] A_PWM  = 2'd3;

    logic [N_LED-1:0] data_q, data_d;
    logic [N_LED-1:0] mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             phase_q, phase_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [N_LED-1:0] led_q, led_d;

    logic             div_wrap;
    logic             pwm_on;
    logic [N_LED-1:0] lit;

    always_comb begin
        data_d    = data_q;
        mode_d    = mode_q;
        div_d     = div_q;
        duty_d    = duty_q;
        div_wrap  = (div_cnt_q >= div_q);
        div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
        phase_d   = div_wrap ? ~phase_q : phase_q;
        pwm_cnt_d = pwm_cnt_q + 1'b1;

        if (WE) begin
            unique case (Addr)
                A_DATA: data_d = Din[N_LED-1:0];
                A_MODE: mode_d = Din[N_LED-1:0];
                A_DIV: begin
                    // Restarting the divider keeps a shrunken period from running past its limit.
                    div_d     = Din[DIV_W-1:0];
                    div_cnt_d = '0;
                    phase_d   = 1'b1;
                end
                A_PWM:  duty_d = Din[PWM_W-1:0];
                default: ;
            endcase
        end

        // Full-scale duty forces on so the wrap cycle of pwm_cnt never blanks the LEDs.
        pwm_on = (&duty_q) | (pwm_cnt_q < duty_q);
        lit    = data_q & (~mode_q | {N_LED{phase_q}}) & {N_LED{pwm_on}};
        led_d  = ACTIVE_LOW ? ~lit : lit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            mode_q    <= '0;
            div_q     <= DIV_RST;
            duty_q    <= '1;
            div_cnt_q <= '0;
            phase_q   <= 1'b1;
            pwm_cnt_q <= '0;
            led_q     <= {N_LED{ACTIVE_LOW}};
        end else begin
            data_q    <= data_d;
            mode_q    <= mode_d;
            div_q     <= div_d;
            duty_q    <= duty_d;
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    always_comb begin
        Dout = '0;
        unique case (Addr)
            A_DATA:  Dout[N_LED-1:0] = data_q;
            A_MODE:  Dout[N_LED-1:0] = mode_q;
            A_DIV:   Dout[DIV_W-1:0] = div_q;
            A_PWM:   Dout[PWM_W-1:0] = duty_q;
            default: Dout = '0;
        endcase
    end

    assign led = led_q;

    logic unused_din;
    assign unused_din = &{1'b0, Din};

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl: one active-low and one active-high instance share stimulus,
// each step compared against hand-derived values with immediate assertions.
module tb_led_ctrl;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] dout_ah;
    logic [7:0]  led;
    logic [7:0]  led_ah;

    int n_vec = 0;
    int n_err = 0;
    int cnt;
    int cnt_ah;

    logic [31:0] exp_rst [4] = '{32'h0, 32'h0, 32'h0, 32'hF};

    led_ctrl #(.N_LED(8), .DIV_W(24), .PWM_W(4), .DIV_RST(24'd0), .ACTIVE_LOW(1'b1)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .WE   (we),
        .Addr (addr),
        .Din  (din),
        .Dout (dout),
        .led  (led)
    );

    led_ctrl #(.N_LED(8), .DIV_W(24), .PWM_W(4), .DIV_RST(24'd0), .ACTIVE_LOW(1'b0)) u_dut_ah (
        .clk  (clk),
        .rst  (rst),
        .WE   (we),
        .Addr (addr),
        .Din  (din),
        .Dout (dout_ah),
        .led  (led_ah)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver: call at a negedge; the write commits on the following posedge and the
    // task returns on the negedge after it, with Addr still selecting that register.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        din  = d;
        @(negedge clk);
        we   = 1'b0;
    endtask

    initial begin
        // 1: reset with a coincident write that must be ignored
        rst  = 1'b1;
        we   = 1'b1;
        addr = 2'd0;
        din  = 32'hFF;
        @(negedge clk);
        rst = 1'b0;
        we  = 1'b0;
        chk("rst_led", {24'h0, led}, 32'hFF);
        chk("rst_led_ah", {24'h0, led_ah}, 32'h00);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            chk($sformatf("rst_dout%0d", a), dout, exp_rst[a]);
        end
        @(negedge clk);

        // 2: static pattern, both polarities
        wr(2'd0, 32'hFFFF_FFA5);
        chk("static_dout", dout, 32'hA5);
        chk("static_dout_ah", dout_ah, 32'hA5);
        chk("static_led_lat", {24'h0, led}, 32'hFF);
        @(negedge clk);
        chk("static_led", {24'h0, led}, 32'h5A);
        chk("static_led_ah", {24'h0, led_ah}, 32'hA5);
        repeat (3) @(negedge clk);
        chk("static_hold", {24'h0, led}, 32'h5A);

        // 3: blink with half-period 4 cycles, divider written last to align phase
        wr(2'd1, 32'h01);
        wr(2'd0, 32'h01);
        wr(2'd2, 32'd3);
        chk("blink_dout", dout, 32'd3);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("blink_k%0d", k), {24'h0, led},
                (((k - 1) / 4) % 2 == 0) ? 32'hFE : 32'hFF);
            chk($sformatf("blink_ah_k%0d", k), {24'h0, led_ah},
                (((k - 1) / 4) % 2 == 0) ? 32'h01 : 32'h00);
        end

        // 4: divider zero toggles each cycle; rewrite on a wrap restarts with phase=1
        wr(2'd2, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("div0_k%0d", k), {24'h0, led}, (k % 2 == 1) ? 32'hFE : 32'hFF);
        end
        wr(2'd2, 32'd2);
        chk("div2_wr", {24'h0, led}, 32'hFE);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("div2_k%0d", k), {24'h0, led}, (k <= 3) ? 32'hFE : 32'hFF);
        end

        // 5: PWM dimming on a static channel
        wr(2'd1, 32'h00);
        wr(2'd3, 32'd4);
        chk("pwm_dout", dout, 32'd4);
        @(negedge clk);
        cnt    = 0;
        cnt_ah = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (led[0] == 1'b0) cnt++;
            if (led_ah[0] == 1'b1) cnt_ah++;
        end
        chk("pwm4_lit", 32'(cnt), 32'd4);
        chk("pwm4_lit_ah", 32'(cnt_ah), 32'd4);

        wr(2'd3, 32'd0);
        @(negedge clk);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (led[0] == 1'b0) cnt++;
        end
        chk("pwm0_lit", 32'(cnt), 32'd0);

        wr(2'd3, 32'hFFFF_FFFF);
        chk("pwm15_dout", dout, 32'hF);
        @(negedge clk);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (led[0] == 1'b0) cnt++;
        end
        chk("pwm15_lit", 32'(cnt), 32'd16);

        // 6: reset in the middle of blinking
        wr(2'd1, 32'h01);
        wr(2'd2, 32'd3);
        wr(2'd3, 32'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_led", {24'h0, led}, 32'hFF);
        chk("mid_rst_led_ah", {24'h0, led_ah}, 32'h00);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            chk($sformatf("mid_rst_dout%0d", a), dout, exp_rst[a]);
        end
        // Divider is back to 0, so phase is 1 on even cycles after the reset edge.
        wr(2'd1, 32'h01);
        wr(2'd0, 32'h01);
        chk("mid_rst_r2", {24'h0, led}, 32'hFF);
        @(negedge clk);
        chk("mid_rst_r3", {24'h0, led}, 32'hFE);
        @(negedge clk);
        chk("mid_rst_r4", {24'h0, led}, 32'hFF);
        @(negedge clk);
        chk("mid_rst_r5", {24'h0, led}, 32'hFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
